// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: icache, dcache and memory line-port signals shared by the arbiter.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  ic_read;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic [LINE_WIDTH-1:0] ic_rdata;
    logic                  ic_resp;
    logic                  dc_read;
    logic                  dc_write;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [LINE_WIDTH-1:0] dc_wdata;
    logic [LINE_WIDTH-1:0] dc_rdata;
    logic                  dc_resp;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, mem_rdata, mem_resp,
        output ic_rdata, ic_resp, dc_rdata, dc_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, mem_rdata, mem_resp,
        input  ic_rdata, ic_resp, dc_rdata, dc_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one memory line port between icache and dcache misses.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic           clk,
    input logic           rst,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t r_state, w_next;
    logic   r_last, w_last;
    logic   w_ireq, w_dreq;

    assign w_ireq = bus.ic_read;
    assign w_dreq = bus.dc_read | bus.dc_write;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last;
        end
    end

    // outputs are forced low while reset is held so an abandoned grant never leaks
    always_comb begin
        w_next        = r_state;
        w_last        = r_last;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata = {LINE_WIDTH{1'b0}};
        bus.ic_rdata  = {LINE_WIDTH{1'b0}};
        bus.ic_resp   = 1'b0;
        bus.dc_rdata  = {LINE_WIDTH{1'b0}};
        bus.dc_resp   = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE: w_next = (w_ireq && (!w_dreq || r_last)) ? SERVE_I : w_dreq ? SERVE_D : IDLE;
                SERVE_I: begin
                    bus.mem_read = 1'b1;
                    bus.mem_addr = bus.ic_addr;
                    if (bus.mem_resp) begin
                        bus.ic_rdata = bus.mem_rdata;
                        bus.ic_resp  = 1'b1;
                        w_last       = 1'b0;
                        w_next       = RELEASE;
                    end
                end
                SERVE_D: begin
                    bus.mem_read  = bus.dc_read & ~bus.dc_write;
                    bus.mem_write = bus.dc_write;
                    bus.mem_addr  = bus.dc_addr;
                    bus.mem_wdata = bus.dc_wdata;
                    if (bus.mem_resp) begin
                        bus.dc_rdata = bus.mem_rdata;
                        bus.dc_resp  = 1'b1;
                        w_last       = 1'b1;
                        w_next       = RELEASE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && r_state == SERVE_D) assert (!(bus.dc_read && bus.dc_write));
    end
endmodule
